// File: rtl/bram_s2_byte_initiator.sv
// Byte-wide initiator for a 2048x2 single-port block RAM with registered read data.
// Each byte occupies four consecutive 2-bit cells; slice k lives at {addr, k}.
// Writes take four RAM write cycles. Reads take four RAM read cycles plus one tail
// cycle, which covers the RAM's registered output, and then the assembled byte is
// presented on a valid/ready response channel.
module bram_s2_byte_initiator #(
    parameter int unsigned RAM_AW = 11
) (
    input  logic              CLK,
    input  logic              RST,
    // byte request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [RAM_AW-3:0] req_addr,
    input  logic [7:0]        req_wdata,
    // byte response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_rdata,
    // RAM primitive side
    output logic [RAM_AW-1:0] ram_addr,
    output logic [1:0]        ram_di,
    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_rst,
    input  logic [1:0]        ram_do
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdTail,
        StRsp
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [RAM_AW-3:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;

    // RAM data lags the address by one cycle, so slot cnt-1 is the slice now on ram_do
    logic [1:0]        rd_slot;

    assign rd_slot = cnt_q - 2'd1;

    // Next-state logic: sequencing, request latching and read-data assembly
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    if (req_we) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                        rdata_d = 8'h00;
                    end
                end
            end

            StWr: begin
                // cnt wraps back to 0 after the last slice
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = StIdle;
                end
            end

            StRd: begin
                if (cnt_q != 2'd0) begin
                    rdata_d[{rd_slot, 1'b0} +: 2] = ram_do;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = StRdTail;
                end
            end

            StRdTail: begin
                rdata_d[7:6] = ram_do;
                state_d      = StRsp;
            end

            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // RAM drive: active only while issuing slices, otherwise held at zero
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = 2'b00;

        unique case (state_q)
            StWr: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = {addr_q, cnt_q};
                ram_di   = wdata_q[{cnt_q, 1'b0} +: 2];
            end
            StRd: begin
                ram_en   = 1'b1;
                ram_addr = {addr_q, cnt_q};
            end
            default: begin
            end
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StRsp);
    assign rsp_rdata = rdata_q;
    // The RAM output-latch reset is unused
    assign ram_rst   = 1'b0;

    // State register with synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
